// File: rtl/apb_pkg.sv
// ---------------------------------------------------------------------------
// apb_pkg
// Shared types and constants for the two-slave APB master controller.
//   apb_state_e : controller FSM states (IDLE, SETUP, ACCESS)
//   DEFAULT_AW  : default address width (MSB selects the slave)
//   DEFAULT_DW  : default data width
//   SLV1_SEL    : value of the address MSB that selects slave 1
//   SLV2_SEL    : value of the address MSB that selects slave 2
//   TIMER_W     : width of the wait-state counter
// ---------------------------------------------------------------------------
package apb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2
   } apb_state_e;

   localparam int unsigned DEFAULT_AW = 9;
   localparam int unsigned DEFAULT_DW = 8;

   localparam logic SLV1_SEL = 1'b0;
   localparam logic SLV2_SEL = 1'b1;

   localparam int unsigned TIMER_W = 8;

endpackage

// File: rtl/apb_wait_timer.sv
// ---------------------------------------------------------------------------
// apb_wait_timer
// Counts ACCESS cycles in which the selected slave holds pready low.
//   pclk    in  : clock, rising edge
//   presetn in  : asynchronous active-low reset
//   clear   in  : synchronous clear (wins over enable)
//   enable  in  : increment the counter this cycle
//   expired out : the current waiting cycle is the TIMEOUT-th one
// ---------------------------------------------------------------------------
module apb_wait_timer
   import apb_pkg::*;
#(
   parameter int unsigned TIMEOUT = 16
) (
   input  logic pclk,
   input  logic presetn,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   logic [TIMER_W-1:0] count_q;
   logic [TIMER_W-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (clear) begin
         count_d = '0;
      end else if (enable) begin
         count_d = count_q + 1'b1;
      end
   end

   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   // count_q holds the number of earlier waiting cycles, so the TIMEOUT-th
   // waiting cycle is the one that sees TIMEOUT-1.
   assign expired = (count_q == TIMER_W'(TIMEOUT - 1));

endmodule

// File: rtl/apb_master_ctrl.sv
// ---------------------------------------------------------------------------
// apb_master_ctrl
// APB master sequencing SETUP/ACCESS towards two slaves selected by the
// address MSB, with wait states, slave errors and a wait-state timeout.
//   pclk, presetn                  : clock / async active-low reset
//   i_ptransfer, i_pwrite          : user request and direction
//   i_pwaddr, i_pwdata, i_praddr   : user write address/data, read address
//   o_ready                        : request accepted this cycle if requested
//   o_done, o_prdata, o_pslverr    : completion pulse, read data, error status
//   o_paddr, o_pwdata, o_pwrite    : APB request bus
//   o_psel1, o_psel2, o_penable    : APB controls
//   i_pready*, i_pslverr*, i_prdata*: per-slave responses
// ---------------------------------------------------------------------------
module apb_master_ctrl
   import apb_pkg::*;
#(
   parameter int unsigned AW      = DEFAULT_AW,
   parameter int unsigned DW      = DEFAULT_DW,
   parameter int unsigned TIMEOUT = 16
) (
   input  logic          pclk,
   input  logic          presetn,
   input  logic          i_ptransfer,
   input  logic          i_pwrite,
   input  logic [AW-1:0] i_pwaddr,
   input  logic [DW-1:0] i_pwdata,
   input  logic [AW-1:0] i_praddr,
   output logic          o_ready,
   output logic          o_done,
   output logic [DW-1:0] o_prdata,
   output logic          o_pslverr,
   output logic [AW-1:0] o_paddr,
   output logic [DW-1:0] o_pwdata,
   output logic          o_pwrite,
   output logic          o_psel1,
   output logic          o_psel2,
   output logic          o_penable,
   input  logic          i_pready1,
   input  logic          i_pready2,
   input  logic          i_pslverr1,
   input  logic          i_pslverr2,
   input  logic [DW-1:0] i_prdata1,
   input  logic [DW-1:0] i_prdata2
);

   apb_state_e    state_q, state_d;
   logic [AW-1:0] paddr_q, paddr_d;
   logic [DW-1:0] pwdata_q, pwdata_d;
   logic          pwrite_q, pwrite_d;
   logic [DW-1:0] prdata_q, prdata_d;
   logic          pslverr_q, pslverr_d;
   logic          done_q, done_d;

   logic          sel2;
   logic          sel_pready;
   logic          sel_pslverr;
   logic [DW-1:0] sel_prdata;
   logic          in_access;
   logic          expired;
   logic          complete;
   logic          accept;
   logic          timer_clear;
   logic          timer_enable;

   // Response mux: only the addressed slave is ever looked at.
   assign sel2        = (paddr_q[AW-1] == SLV2_SEL);
   assign sel_pready  = sel2 ? i_pready2  : i_pready1;
   assign sel_pslverr = sel2 ? i_pslverr2 : i_pslverr1;
   assign sel_prdata  = sel2 ? i_prdata2  : i_prdata1;

   assign in_access = (state_q == ACCESS);
   // A normal ready response wins over a timeout landing on the same cycle.
   assign complete  = in_access && (sel_pready || expired);
   assign o_ready   = (state_q == IDLE) || complete;
   assign accept    = i_ptransfer && o_ready;

   // Outside ACCESS the counter is held at zero, so entering SETUP always
   // starts from a clean count.
   assign timer_clear  = complete || !in_access;
   assign timer_enable = in_access && !sel_pready;

   apb_wait_timer #(
      .TIMEOUT (TIMEOUT)
   ) u_wait_timer (
      .pclk    (pclk),
      .presetn (presetn),
      .clear   (timer_clear),
      .enable  (timer_enable),
      .expired (expired)
   );

   always_comb begin
      state_d   = state_q;
      paddr_d   = paddr_q;
      pwdata_d  = pwdata_q;
      pwrite_d  = pwrite_q;
      prdata_d  = prdata_q;
      pslverr_d = 1'b0;
      done_d    = 1'b0;

      if (accept) begin
         pwrite_d = i_pwrite;
         paddr_d  = i_pwrite ? i_pwaddr : i_praddr;
         if (i_pwrite) begin
            pwdata_d = i_pwdata;
         end
      end

      unique case (state_q)
         IDLE: begin
            if (accept) begin
               state_d = SETUP;
            end
         end
         SETUP: begin
            state_d = ACCESS;
         end
         ACCESS: begin
            if (complete) begin
               done_d  = 1'b1;
               state_d = accept ? SETUP : IDLE;
               if (sel_pready) begin
                  pslverr_d = sel_pslverr;
                  if (!pwrite_q) begin
                     prdata_d = sel_prdata;
                  end
               end else begin
                  // Timeout abort: flag an error, keep the last read data.
                  pslverr_d = 1'b1;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         state_q   <= IDLE;
         paddr_q   <= '0;
         pwdata_q  <= '0;
         pwrite_q  <= 1'b0;
         prdata_q  <= '0;
         pslverr_q <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         paddr_q   <= paddr_d;
         pwdata_q  <= pwdata_d;
         pwrite_q  <= pwrite_d;
         prdata_q  <= prdata_d;
         pslverr_q <= pslverr_d;
         done_q    <= done_d;
      end
   end

   // Selects and enable decode straight from state so an async reset drops
   // them at once.
   assign o_psel1   = (state_q != IDLE) && (paddr_q[AW-1] == SLV1_SEL);
   assign o_psel2   = (state_q != IDLE) && (paddr_q[AW-1] == SLV2_SEL);
   assign o_penable = in_access;

   assign o_paddr   = paddr_q;
   assign o_pwdata  = pwdata_q;
   assign o_pwrite  = pwrite_q;
   assign o_prdata  = prdata_q;
   assign o_pslverr = pslverr_q;
   assign o_done    = done_q;

endmodule

// File: tb/tb_apb_master_ctrl.sv
module tb_apb_master_ctrl;

   localparam int unsigned AW = 9;
   localparam int unsigned DW = 8;
   localparam int unsigned TIMEOUT = 16;

   logic          pclk;
   logic          presetn;
   logic          i_ptransfer;
   logic          i_pwrite;
   logic [AW-1:0] i_pwaddr;
   logic [DW-1:0] i_pwdata;
   logic [AW-1:0] i_praddr;
   logic          o_ready;
   logic          o_done;
   logic [DW-1:0] o_prdata;
   logic          o_pslverr;
   logic [AW-1:0] o_paddr;
   logic [DW-1:0] o_pwdata;
   logic          o_pwrite;
   logic          o_psel1;
   logic          o_psel2;
   logic          o_penable;
   logic          i_pready1;
   logic          i_pready2;
   logic          i_pslverr1;
   logic          i_pslverr2;
   logic [DW-1:0] i_prdata1;
   logic [DW-1:0] i_prdata2;

   int n_checks;
   int n_fails;

   apb_master_ctrl #(
      .AW      (AW),
      .DW      (DW),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .pclk        (pclk),
      .presetn     (presetn),
      .i_ptransfer (i_ptransfer),
      .i_pwrite    (i_pwrite),
      .i_pwaddr    (i_pwaddr),
      .i_pwdata    (i_pwdata),
      .i_praddr    (i_praddr),
      .o_ready     (o_ready),
      .o_done      (o_done),
      .o_prdata    (o_prdata),
      .o_pslverr   (o_pslverr),
      .o_paddr     (o_paddr),
      .o_pwdata    (o_pwdata),
      .o_pwrite    (o_pwrite),
      .o_psel1     (o_psel1),
      .o_psel2     (o_psel2),
      .o_penable   (o_penable),
      .i_pready1   (i_pready1),
      .i_pready2   (i_pready2),
      .i_pslverr1  (i_pslverr1),
      .i_pslverr2  (i_pslverr2),
      .i_prdata1   (i_prdata1),
      .i_prdata2   (i_prdata2)
   );

   initial pclk = 1'b0;
   always #5 pclk = ~pclk;

   // Controls are grouped as {psel1, psel2, penable}.
   task automatic test_reset();
      #3;
      n_checks++;
      if ({o_psel1, o_psel2, o_penable} !== 3'b000) begin
         n_fails++;
         $display("FAIL reset_ctrl: got %b expected 000", {o_psel1, o_psel2, o_penable});
      end
      n_checks++;
      if ({o_paddr, o_pwdata, o_pwrite, o_prdata, o_pslverr, o_done} !== '0) begin
         n_fails++;
         $display("FAIL reset_regs: paddr %h pwdata %h pwrite %b prdata %h pslverr %b done %b",
                  o_paddr, o_pwdata, o_pwrite, o_prdata, o_pslverr, o_done);
      end
      n_checks++;
      if (o_ready !== 1'b1) begin
         n_fails++;
         $display("FAIL reset_ready: got %b expected 1", o_ready);
      end
      @(negedge pclk);
      presetn = 1'b1;
   endtask

   task automatic test_write();
      @(negedge pclk);
      i_ptransfer = 1'b1; i_pwrite = 1'b1; i_pwaddr = 9'h005; i_pwdata = 8'hA5;
      i_praddr = 9'h1FF;
      #1;
      n_checks++;
      if (o_ready !== 1'b1) begin
         n_fails++; $display("FAIL wr_ready_idle: got %b expected 1", o_ready);
      end
      @(negedge pclk);  // SETUP
      i_ptransfer = 1'b0;
      #1;
      n_checks++;
      if ({o_psel1, o_psel2, o_penable, o_ready, o_done} !== 5'b10000) begin
         n_fails++;
         $display("FAIL wr_setup_ctrl: got %b expected 10000",
                  {o_psel1, o_psel2, o_penable, o_ready, o_done});
      end
      n_checks++;
      if ({o_paddr, o_pwdata, o_pwrite} !== {9'h005, 8'hA5, 1'b1}) begin
         n_fails++;
         $display("FAIL wr_setup_bus: got %h/%h/%b expected 005/a5/1", o_paddr, o_pwdata, o_pwrite);
      end
      @(negedge pclk);  // ACCESS
      #1;
      n_checks++;
      if ({o_psel1, o_psel2, o_penable, o_done} !== 4'b1010) begin
         n_fails++;
         $display("FAIL wr_access_ctrl: got %b expected 1010", {o_psel1, o_psel2, o_penable, o_done});
      end
      @(negedge pclk);  // done cycle, back in IDLE
      #1;
      n_checks++;
      if ({o_done, o_pslverr, o_psel1, o_psel2, o_penable} !== 5'b10000) begin
         n_fails++;
         $display("FAIL wr_done: got %b expected 10000",
                  {o_done, o_pslverr, o_psel1, o_psel2, o_penable});
      end
      @(negedge pclk);
      #1;
      n_checks++;
      if (o_done !== 1'b0) begin
         n_fails++; $display("FAIL wr_done_pulse: got %b expected 0", o_done);
      end
   endtask

   task automatic test_read_wait();
      @(negedge pclk);
      i_pready2 = 1'b0; i_prdata2 = 8'h3C; i_prdata1 = 8'hEE;
      i_ptransfer = 1'b1; i_pwrite = 1'b0; i_praddr = 9'h105; i_pwaddr = 9'h000;
      @(negedge pclk);  // SETUP
      i_ptransfer = 1'b0;
      #1;
      n_checks++;
      if ({o_psel1, o_psel2, o_penable, o_paddr, o_pwrite} !== {3'b010, 9'h105, 1'b0}) begin
         n_fails++;
         $display("FAIL rd_setup: ctrl %b paddr %h pwrite %b expected 010/105/0",
                  {o_psel1, o_psel2, o_penable}, o_paddr, o_pwrite);
      end
      for (int i = 0; i < 2; i++) begin
         @(negedge pclk);  // ACCESS with wait
         #1;
         n_checks++;
         if ({o_psel1, o_psel2, o_penable, o_ready, o_done} !== 5'b01100) begin
            n_fails++;
            $display("FAIL rd_wait%0d: got %b expected 01100", i,
                     {o_psel1, o_psel2, o_penable, o_ready, o_done});
         end
      end
      @(negedge pclk);  // third ACCESS cycle
      i_pready2 = 1'b1;
      #1;
      n_checks++;
      if ({o_psel2, o_penable, o_ready} !== 3'b111) begin
         n_fails++;
         $display("FAIL rd_access3: got %b expected 111", {o_psel2, o_penable, o_ready});
      end
      @(negedge pclk);
      #1;
      n_checks++;
      if ({o_done, o_pslverr, o_prdata} !== {2'b10, 8'h3C}) begin
         n_fails++;
         $display("FAIL rd_done: done %b pslverr %b prdata %h expected 1/0/3c",
                  o_done, o_pslverr, o_prdata);
      end
   endtask

   task automatic test_back_to_back();
      @(negedge pclk);
      i_ptransfer = 1'b1; i_pwrite = 1'b1; i_pwaddr = 9'h010; i_pwdata = 8'h11;
      i_prdata2 = 8'h5A;
      @(negedge pclk);  // SETUP of write; request already switched to the read
      i_pwrite = 1'b0; i_praddr = 9'h120; i_pwdata = 8'hFF;
      #1;
      n_checks++;
      if ({o_paddr, o_pwdata, o_pwrite, o_ready} !== {9'h010, 8'h11, 1'b1, 1'b0}) begin
         n_fails++;
         $display("FAIL b2b_setup1: paddr %h pwdata %h pwrite %b ready %b expected 010/11/1/0",
                  o_paddr, o_pwdata, o_pwrite, o_ready);
      end
      @(negedge pclk);  // ACCESS of write, completes and accepts the read
      #1;
      n_checks++;
      if ({o_psel1, o_psel2, o_penable, o_ready} !== 4'b1011) begin
         n_fails++;
         $display("FAIL b2b_access1: got %b expected 1011", {o_psel1, o_psel2, o_penable, o_ready});
      end
      @(negedge pclk);  // SETUP of read coincides with write done
      i_ptransfer = 1'b0;
      #1;
      n_checks++;
      if ({o_done, o_psel1, o_psel2, o_penable} !== 4'b1010) begin
         n_fails++;
         $display("FAIL b2b_setup2: got %b expected 1010", {o_done, o_psel1, o_psel2, o_penable});
      end
      n_checks++;
      if ({o_paddr, o_pwrite, o_prdata} !== {9'h120, 1'b0, 8'h3C}) begin
         n_fails++;
         $display("FAIL b2b_bus2: paddr %h pwrite %b prdata %h expected 120/0/3c",
                  o_paddr, o_pwrite, o_prdata);
      end
      @(negedge pclk);  // ACCESS of read
      #1;
      n_checks++;
      if ({o_done, o_psel2, o_penable} !== 3'b011) begin
         n_fails++; $display("FAIL b2b_access2: got %b expected 011", {o_done, o_psel2, o_penable});
      end
      @(negedge pclk);
      #1;
      n_checks++;
      if ({o_done, o_prdata} !== {1'b1, 8'h5A}) begin
         n_fails++;
         $display("FAIL b2b_done2: done %b prdata %h expected 1/5a", o_done, o_prdata);
      end
   endtask

   task automatic test_timeout();
      @(negedge pclk);
      i_pready1 = 1'b0; i_prdata1 = 8'h99;
      i_ptransfer = 1'b1; i_pwrite = 1'b0; i_praddr = 9'h0AA;
      @(negedge pclk);  // SETUP
      i_ptransfer = 1'b0;
      for (int i = 0; i < int'(TIMEOUT); i++) begin
         @(negedge pclk);
         #1;
         n_checks++;
         if ({o_psel1, o_penable, o_done, o_ready} !== {3'b110, (i == int'(TIMEOUT) - 1)}) begin
            n_fails++;
            $display("FAIL to_access%0d: got %b expected %b", i,
                     {o_psel1, o_penable, o_done, o_ready},
                     {3'b110, (i == int'(TIMEOUT) - 1)});
         end
      end
      @(negedge pclk);
      #1;
      n_checks++;
      if ({o_done, o_pslverr, o_prdata} !== {2'b11, 8'h5A}) begin
         n_fails++;
         $display("FAIL to_done: done %b pslverr %b prdata %h expected 1/1/5a",
                  o_done, o_pslverr, o_prdata);
      end
      n_checks++;
      if ({o_psel1, o_psel2, o_penable, o_ready} !== 4'b0001) begin
         n_fails++;
         $display("FAIL to_idle: got %b expected 0001", {o_psel1, o_psel2, o_penable, o_ready});
      end
      i_pready1 = 1'b1;
   endtask

   task automatic test_slverr();
      @(negedge pclk);
      i_pready2 = 1'b1; i_pslverr2 = 1'b1; i_prdata2 = 8'hC3;
      i_ptransfer = 1'b1; i_pwrite = 1'b0; i_praddr = 9'h1C0;
      @(negedge pclk);  // SETUP
      i_ptransfer = 1'b0;
      @(negedge pclk);  // ACCESS
      @(negedge pclk);
      #1;
      n_checks++;
      if ({o_done, o_pslverr, o_prdata} !== {2'b11, 8'hC3}) begin
         n_fails++;
         $display("FAIL err_done: done %b pslverr %b prdata %h expected 1/1/c3",
                  o_done, o_pslverr, o_prdata);
      end
      @(negedge pclk);
      #1;
      n_checks++;
      if ({o_done, o_pslverr} !== 2'b00) begin
         n_fails++; $display("FAIL err_clear: got %b expected 00", {o_done, o_pslverr});
      end
      i_pslverr2 = 1'b0;
   endtask

   task automatic test_reset_mid();
      @(negedge pclk);
      i_pready2 = 1'b0;
      i_ptransfer = 1'b1; i_pwrite = 1'b1; i_pwaddr = 9'h150; i_pwdata = 8'h77;
      @(negedge pclk);  // SETUP
      i_ptransfer = 1'b0;
      @(negedge pclk);  // ACCESS, waiting
      @(negedge pclk);  // ACCESS, waiting
      #2;
      presetn = 1'b0;
      #1;
      n_checks++;
      if ({o_psel1, o_psel2, o_penable, o_done, o_ready} !== 5'b00001) begin
         n_fails++;
         $display("FAIL rst_mid_ctrl: got %b expected 00001",
                  {o_psel1, o_psel2, o_penable, o_done, o_ready});
      end
      @(negedge pclk);
      #1;
      n_checks++;
      if ({o_done, o_prdata, o_paddr} !== '0) begin
         n_fails++;
         $display("FAIL rst_mid_regs: done %b prdata %h paddr %h expected 0/00/000",
                  o_done, o_prdata, o_paddr);
      end
      presetn = 1'b1;
      i_pready2 = 1'b1;
      @(negedge pclk);
      i_ptransfer = 1'b1; i_pwrite = 1'b1; i_pwaddr = 9'h007; i_pwdata = 8'h42;
      @(negedge pclk);  // SETUP
      i_ptransfer = 1'b0;
      #1;
      n_checks++;
      if ({o_psel1, o_psel2, o_penable, o_paddr, o_pwdata} !== {3'b100, 9'h007, 8'h42}) begin
         n_fails++;
         $display("FAIL rst_new_setup: ctrl %b paddr %h pwdata %h expected 100/007/42",
                  {o_psel1, o_psel2, o_penable}, o_paddr, o_pwdata);
      end
      @(negedge pclk);  // ACCESS
      @(negedge pclk);
      #1;
      n_checks++;
      if ({o_done, o_pslverr} !== 2'b10) begin
         n_fails++; $display("FAIL rst_new_done: got %b expected 10", {o_done, o_pslverr});
      end
   endtask

   initial begin
      n_checks    = 0;
      n_fails     = 0;
      presetn     = 1'b0;
      i_ptransfer = 1'b0;
      i_pwrite    = 1'b0;
      i_pwaddr    = '0;
      i_pwdata    = '0;
      i_praddr    = '0;
      i_pready1   = 1'b1;
      i_pready2   = 1'b1;
      i_pslverr1  = 1'b0;
      i_pslverr2  = 1'b0;
      i_prdata1   = 8'hEE;
      i_prdata2   = 8'h77;

      test_reset();
      test_write();
      test_read_wait();
      test_back_to_back();
      test_timeout();
      test_slverr();
      test_reset_mid();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
